// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO with status flags, sticky overflow and flush
module param_fifo #(
  parameter int DATA_WIDTH  = 21,
  parameter int ADDR_WIDTH  = 3,
  parameter int ALMOST_FULL = 6,
  parameter int PULSE_GAP   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  input  logic                  i_in_data_available,
  output logic                  o_in_ready,
  input  logic                  i_receiver_ready,
  output logic                  o_out_data_available,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_overflow
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_out_data_available;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_overflow;

  logic w_full;
  logic w_empty;
  logic w_gap_ok;
  logic w_wr;
  logic w_rd;

  // Status is decoded from the registered occupancy, never from pointer equality.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_gap_ok = (PULSE_GAP == 0) || !r_out_data_available;
  assign w_wr     = i_in_data_available && !w_full;
  assign w_rd     = i_receiver_ready && !w_empty && w_gap_ok;

  assign o_in_ready           = !w_full;
  assign o_full               = w_full;
  assign o_empty              = w_empty;
  assign o_almost_full        = (r_count >= AF_C);
  assign o_count              = r_count;
  assign o_out_data_available = r_out_data_available;
  assign o_out_data           = r_out_data;
  assign o_overflow           = r_overflow;

  // Storage array: written on accepted writes only, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && w_wr) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // Pointers, occupancy, output register and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr             <= '0;
      r_rd_ptr             <= '0;
      r_count              <= '0;
      r_out_data_available <= 1'b0;
      r_out_data           <= '0;
      r_overflow           <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr             <= '0;
      r_rd_ptr             <= '0;
      r_count              <= '0;
      r_out_data_available <= 1'b0;
      r_overflow           <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (i_in_data_available && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_rd) begin
        r_out_data           <= r_mem[r_rd_ptr];
        r_rd_ptr             <= r_rd_ptr + ADDR_WIDTH'(1);
        r_out_data_available <= 1'b1;
      end else begin
        r_out_data_available <= 1'b0;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo, legacy-gap and streaming instances
module tb_param_fifo;

  localparam int DW = 21;
  localparam int AW = 3;
  localparam int DEPTH = 8;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_dav = 1'b0;
  logic          rr = 1'b0;

  logic          in_ready [2];
  logic          oda      [2];
  logic [DW-1:0] odata    [2];
  logic [AW:0]   cnt      [2];
  logic          empty    [2];
  logic          full     [2];
  logic          afull    [2];
  logic          ovf      [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue per instance; index 0 is streaming, 1 is legacy gap.
  logic [DW-1:0] mq [2][$];
  logic          m_oda  [2];
  logic [DW-1:0] m_od   [2];
  logic          m_ovf  [2];

  always #5 clk = ~clk;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL(AF), .PULSE_GAP(0)) u_stream (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_data(in_data),
    .i_in_data_available(in_dav), .o_in_ready(in_ready[0]), .i_receiver_ready(rr),
    .o_out_data_available(oda[0]), .o_out_data(odata[0]), .o_count(cnt[0]),
    .o_empty(empty[0]), .o_full(full[0]), .o_almost_full(afull[0]), .o_overflow(ovf[0])
  );

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL(AF), .PULSE_GAP(1)) u_gap (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_in_data(in_data),
    .i_in_data_available(in_dav), .o_in_ready(in_ready[1]), .i_receiver_ready(rr),
    .o_out_data_available(oda[1]), .o_out_data(odata[1]), .o_count(cnt[1]),
    .o_empty(empty[1]), .o_full(full[1]), .o_almost_full(afull[1]), .o_overflow(ovf[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int g);
    int sz;
    logic do_rd;
    sz = mq[g].size();
    if (reset) begin
      mq[g].delete();
      m_oda[g] = 1'b0;
      m_od[g]  = '0;
      m_ovf[g] = 1'b0;
    end else if (flush) begin
      mq[g].delete();
      m_oda[g] = 1'b0;
      m_ovf[g] = 1'b0;
    end else begin
      do_rd = rr && (sz != 0) && (g == 0 || !m_oda[g]);
      if (do_rd) begin
        m_od[g]  = mq[g].pop_front();
        m_oda[g] = 1'b1;
      end else begin
        m_oda[g] = 1'b0;
      end
      if (in_dav && sz == DEPTH) m_ovf[g] = 1'b1;
      if (in_dav && sz != DEPTH) mq[g].push_back(in_data);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 2; g++) begin
      int sz;
      sz = mq[g].size();
      chk($sformatf("g%0d_oda", g),   32'(oda[g]),      32'(m_oda[g]));
      chk($sformatf("g%0d_odata", g), 32'(odata[g]),    32'(m_od[g]));
      chk($sformatf("g%0d_count", g), 32'(cnt[g]),      32'(sz));
      chk($sformatf("g%0d_empty", g), 32'(empty[g]),    32'(sz == 0));
      chk($sformatf("g%0d_full", g),  32'(full[g]),     32'(sz == DEPTH));
      chk($sformatf("g%0d_afull", g), 32'(afull[g]),    32'(sz >= AF));
      chk($sformatf("g%0d_inrdy", g), 32'(in_ready[g]), 32'(sz != DEPTH));
      chk($sformatf("g%0d_ovf", g),   32'(ovf[g]),      32'(m_ovf[g]));
    end
  endtask

  task automatic step(input logic wda, input logic [DW-1:0] d, input logic r,
                      input logic fl, input logic rst);
    in_dav  = wda;
    in_data = d;
    rr      = r;
    flush   = fl;
    reset   = rst;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(empty[1]), 32'd1);
    chk("rst_inrdy", 32'(in_ready[0]), 32'd1);

    // 1: three writes with consumer ready
    for (int i = 1; i <= 3; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 2: nine writes with consumer stalled, then drain
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
      chk("t2_afull", 32'(afull[1]), 32'(i >= 6));
    end
    chk("t2_count", 32'(cnt[1]), 32'd8);
    chk("t2_ovf", 32'(ovf[0]), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 3: pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, DW'(16'h200 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t3_empty", 32'(empty[1]), 32'd1);

    // 4: streaming burst of four
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h300 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_stream_oda", 32'(oda[0]), 32'd1);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // 5: simultaneous write+read at full and at empty
    for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h400 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(21'h1ABCD), 1'b1, 1'b0, 1'b0);
    chk("t5_full_count", 32'(cnt[0]), 32'd7);
    chk("t5_full_ovf", 32'(ovf[1]), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, DW'(21'h0BEEF), 1'b1, 1'b0, 1'b0);
    chk("t5_empty_oda", 32'(oda[0]), 32'd0);
    chk("t5_empty_count", 32'(cnt[1]), 32'd1);

    // 6: flush with data, overflow and a write strobe
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h500 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(21'h12345), 1'b1, 1'b1, 1'b0);
    chk("t6_count", 32'(cnt[0]), 32'd0);
    chk("t6_ovf", 32'(ovf[1]), 32'd0);
    step(1'b1, DW'(21'h00777), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 6), DW'($urandom()), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
